// File: rtl/throw_turn_ctl_pkg.sv
// Shared types and constants for the throw turn controller: turn/state enums,
// wind range constants and small arithmetic helpers.
package throw_turn_ctl_pkg;

  typedef enum logic {
    TURN_CAT = 1'b0,
    TURN_DOG = 1'b1
  } turn_e;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    THROW,
    RELEASE,
    SCORE,
    OVER
  } turn_state_e;

  localparam int HP_W    = 4;
  localparam int WIND_W  = 7;
  localparam int FORCE_W = 10;

  localparam logic [WIND_W-1:0] WIND_CALM = 7'd50;
  localparam logic [WIND_W-1:0] WIND_MAX  = 7'd100;
  localparam logic [WIND_W-1:0] LFSR_SEED = 7'h5A;

  // Folds the 1..127 LFSR range into 0..100 by pulling the top values down.
  function automatic logic [WIND_W-1:0] wind_map(input logic [WIND_W-1:0] v);
    return (v > WIND_MAX) ? (v - 7'd27) : v;
  endfunction

  function automatic logic [HP_W-1:0] hp_sub_sat(input logic [HP_W-1:0] hp,
                                                 input logic [HP_W-1:0] dmg);
    return (hp > dmg) ? (hp - dmg) : '0;
  endfunction

endpackage

// File: rtl/throw_turn_ctl_if.sv
// Enable/done/hit handshake between the turn controller (master) and the
// cat/dog throw controllers (slave side).
interface throw_turn_ctl_if;
  import throw_turn_ctl_pkg::*;

  logic               enable_cat;
  logic               enable_dog;
  logic               throw_done_cat;
  logic               throw_done_dog;
  logic               hit_cat;
  logic               hit_dog;
  logic [FORCE_W-1:0] throw_force;
  logic [WIND_W-1:0]  wind_force;

  modport master (
    output enable_cat, enable_dog, throw_force, wind_force,
    input  throw_done_cat, throw_done_dog, hit_cat, hit_dog
  );

  modport slave (
    input  enable_cat, enable_dog, throw_force, wind_force,
    output throw_done_cat, throw_done_dog, hit_cat, hit_dog
  );

endinterface

// File: rtl/throw_turn_ctl_wind_lfsr.sv
// Free-running 7-bit LFSR (x^7+x^6+1) whose value is folded into a 0..100 wind
// reading and captured only when draw is asserted.
module wind_lfsr
  import throw_turn_ctl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              draw,
  output logic [WIND_W-1:0] wind
);

  logic [WIND_W-1:0] lfsr_reg;
  logic [WIND_W-1:0] wind_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_reg <= LFSR_SEED;
      wind_reg <= WIND_CALM;
    end else begin
      lfsr_reg <= {lfsr_reg[WIND_W-2:0], lfsr_reg[6] ^ lfsr_reg[5]};
      if (draw) begin
        wind_reg <= wind_map(lfsr_reg);
      end
    end
  end

  assign wind = wind_reg;

endmodule

// File: rtl/throw_turn_ctl.sv
// Turn/round controller: alternates cat and dog throws over the enable/done
// handshake, latches force and wind, scores hits and declares the winner.
module throw_turn_ctl
  import throw_turn_ctl_pkg::*;
#(
  parameter int HP_INIT    = 5,
  parameter int DAMAGE     = 1,
  parameter int TICK_DIV   = 65000,
  parameter int TIMEOUT_TK = 5000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               throw_req,
  input  logic [FORCE_W-1:0] force_in,
  throw_turn_ctl_if.master   thr,
  output logic               turn,
  output logic [HP_W-1:0]    hp_cat,
  output logic [HP_W-1:0]    hp_dog,
  output logic               game_over,
  output logic               winner
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TO_W   = (TIMEOUT_TK > 1) ? $clog2(TIMEOUT_TK) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_TK - 1);
  localparam logic [HP_W-1:0]   HP_RELOAD = HP_W'(HP_INIT);
  localparam logic [HP_W-1:0]   DMG       = HP_W'(DAMAGE);

  turn_state_e        state_reg;
  turn_e              turn_reg;
  logic               enable_cat_reg;
  logic               enable_dog_reg;
  logic [FORCE_W-1:0] throw_force_reg;
  logic               hit_seen_reg;
  logic               game_over_reg;
  logic               winner_reg;
  logic [TICK_W-1:0]  tick_cnt_reg;
  logic [TO_W-1:0]    to_cnt_reg;

  logic            done_act;
  logic            hit_act;
  logic            tick;
  logic            timed_out;
  logic [HP_W-1:0] target_hp;
  logic [HP_W-1:0] target_hp_next;
  logic            score_over;
  logic            game_start;
  logic            arm_entry;

  // Only the side whose turn it is may end the throw or score.
  always_comb begin
    done_act       = (turn_reg == TURN_DOG) ? thr.throw_done_dog : thr.throw_done_cat;
    hit_act        = (turn_reg == TURN_DOG) ? thr.hit_dog : thr.hit_cat;
    tick           = (tick_cnt_reg == TICK_LAST);
    timed_out      = tick && (to_cnt_reg == TO_LAST);
    target_hp      = (turn_reg == TURN_DOG) ? hp_cat : hp_dog;
    target_hp_next = hit_seen_reg ? hp_sub_sat(target_hp, DMG) : target_hp;
    score_over     = hit_seen_reg && (target_hp_next == '0);
    game_start     = start && ((state_reg == IDLE) || (state_reg == OVER));
    arm_entry      = game_start || ((state_reg == SCORE) && !score_over);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      turn_reg        <= TURN_CAT;
      enable_cat_reg  <= 1'b0;
      enable_dog_reg  <= 1'b0;
      throw_force_reg <= '0;
      hit_seen_reg    <= 1'b0;
      game_over_reg   <= 1'b0;
      winner_reg      <= 1'b0;
      tick_cnt_reg    <= '0;
      to_cnt_reg      <= '0;
    end else begin
      tick_cnt_reg <= tick ? '0 : tick_cnt_reg + 1'b1;
      case (state_reg)
        IDLE, OVER: begin
          if (start) begin
            state_reg     <= ARM;
            turn_reg      <= TURN_CAT;
            game_over_reg <= 1'b0;
          end
        end
        ARM: begin
          if (throw_req) begin
            state_reg       <= THROW;
            throw_force_reg <= force_in;
            hit_seen_reg    <= 1'b0;
            tick_cnt_reg    <= '0;
            to_cnt_reg      <= '0;
            enable_cat_reg  <= (turn_reg == TURN_CAT);
            enable_dog_reg  <= (turn_reg == TURN_DOG);
          end
        end
        THROW: begin
          if (hit_act) begin
            hit_seen_reg <= 1'b1;
          end
          if (tick) begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
          end
          if (done_act || timed_out) begin
            state_reg      <= RELEASE;
            enable_cat_reg <= 1'b0;
            enable_dog_reg <= 1'b0;
          end
        end
        RELEASE: begin
          if (hit_act) begin
            hit_seen_reg <= 1'b1;
          end
          if (!done_act) begin
            state_reg <= SCORE;
          end
        end
        SCORE: begin
          if (score_over) begin
            state_reg     <= OVER;
            game_over_reg <= 1'b1;
            winner_reg    <= turn_reg;
          end else begin
            state_reg <= ARM;
            turn_reg  <= (turn_reg == TURN_CAT) ? TURN_DOG : TURN_CAT;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Per-player hit points: index 0 is the cat, index 1 the dog. A player is the
  // damage target while the other side holds the turn.
  for (genvar gi = 0; gi < 2; gi++) begin : gen_hp
    logic hp_target;
    logic [HP_W-1:0] hp_reg;

    assign hp_target = ((turn_reg == TURN_DOG) == (gi == 0));

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        hp_reg <= HP_RELOAD;
      end else if (game_start) begin
        hp_reg <= HP_RELOAD;
      end else if ((state_reg == SCORE) && hp_target) begin
        hp_reg <= target_hp_next;
      end
    end
  end

  wind_lfsr u_wind (
    .clk   (clk),
    .rst_n (rst_n),
    .draw  (arm_entry),
    .wind  (thr.wind_force)
  );

  assign thr.enable_cat  = enable_cat_reg;
  assign thr.enable_dog  = enable_dog_reg;
  assign thr.throw_force = throw_force_reg;
  assign turn            = turn_reg;
  assign hp_cat          = gen_hp[0].hp_reg;
  assign hp_dog          = gen_hp[1].hp_reg;
  assign game_over       = game_over_reg;
  assign winner          = winner_reg;

endmodule
